// File: rtl/dmem_initiator_if.sv
// Bundles the core request/response handshake and the Data_Memory access port
// of the dmem_initiator. The initiator connects to the slave modport.
interface dmem_initiator_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // Core request/response side
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Data_Memory side
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        load_type;
    logic [2:0]        store_type;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd, mem_wr, addr, load_type, store_type, wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd, mem_wr, addr, load_type, store_type, wd
    );
endinterface

// File: rtl/dmem_initiator.sv
// Single-outstanding load/store controller in front of Data_Memory: legality check,
// one access cycle, response handshake. Optional alignment check: DMEM_ALIGN_CHECK_EN.
module dmem_initiator #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_initiator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        load_type_q;
    logic [2:0]        store_type_q;
    logic [DATA_W-1:0] wd_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              req_legal;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        req_legal = 1'b0;
        if (bus.req_we) begin
            req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
`ifdef DMEM_ALIGN_CHECK_EN
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) begin
            req_legal = 1'b0;
        end
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) begin
            req_legal = 1'b0;
        end
`endif
    end

    // Decoded from state only; gated by rst_n so it reads 0 while reset is held.
    assign bus.req_ready  = rst_n && (state_q == IDLE);
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.addr       = addr_q;
    assign bus.load_type  = load_type_q;
    assign bus.store_type = store_type_q;
    assign bus.wd         = wd_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: reset clears all state asynchronously, including an in-flight
        // mem_wr, so a store still in ACCESS never reaches memory.
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            addr_q       <= '0;
            load_type_q  <= '0;
            store_type_q <= '0;
            wd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_legal) begin
                            addr_q <= bus.req_addr;
                            wd_q   <= bus.req_wdata;
                            if (bus.req_we) begin
                                store_type_q <= bus.req_funct3;
                                mem_wr_q     <= 1'b1;
                            end else begin
                                load_type_q <= bus.req_funct3;
                                mem_rd_q    <= 1'b1;
                            end
                            state_q <= ACCESS;
                        end else begin
                            // Rejected requests never touch the memory port.
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    if (mem_wr_q) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    resp_rdata_q <= bus.rd;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
